// File: rtl/decoder_pkg.sv
// decoder_pkg: shared constants and pure decode helpers for the URCPU
// binary-to-one-hot decoder. Helpers work on 64-bit vectors so every legal
// BIT_WIDTH (2..64) can reuse them without truncating the index.
package decoder_pkg;

  localparam int unsigned DEC_DEFAULT_WIDTH = 20;
  localparam int unsigned DEC_MAX_WIDTH     = 64;

  // True when index addresses a real output bit. Full-width unsigned compare,
  // so large indices never wrap back into range.
  function automatic logic dec_in_range(input logic [63:0] index,
                                        input logic [63:0] width);
    return (index < width);
  endfunction

  // One-hot vector with bit [index] set, or all-zero when index >= width.
  function automatic logic [63:0] dec_onehot(input logic [63:0] index,
                                             input logic [63:0] width);
    logic [63:0] vec;
    vec = '0;
    for (int i = 0; i < 64; i++) begin
      if ((64'(i) < width) && (index == 64'(i))) begin
        vec[i] = 1'b1;
      end
    end
    return vec;
  endfunction

endpackage

// File: rtl/decoder_onehot_core.sv
// decoder_onehot_core: purely combinational decode of an unsigned index into
// a one-hot vector plus an out-of-range flag. No state.
module decoder_onehot_core
  import decoder_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEC_DEFAULT_WIDTH
) (
  input  logic [BIT_WIDTH-1:0] index_i,
  output logic [BIT_WIDTH-1:0] onehot_o,
  output logic                 out_of_range_o
);

  logic [63:0] index_ext;
  logic [63:0] onehot_full;

  // Zero-extend once so the helpers always see the full unsigned index.
  always_comb begin
    index_ext      = 64'(index_i);
    onehot_full    = dec_onehot(index_ext, 64'(BIT_WIDTH));
    onehot_o       = onehot_full[BIT_WIDTH-1:0];
    out_of_range_o = ~dec_in_range(index_ext, 64'(BIT_WIDTH));
  end

endmodule

// File: rtl/decoder.sv
// decoder: binary-to-one-hot decoder for the URCPU datapath.
// Default build: one registered stage, 1-cycle latency, outputs hold while
// in_valid is low, synchronous active-high reset clears everything.
// Define DECODER_COMB_OUT_EN to bypass the register stage entirely: outputs
// follow input_bits / in_valid combinationally and no flops are built.
//
// Handshake: in_valid qualifies input_bits on a rising clk edge; out_valid
// marks output_bits/out_of_range as carrying a decode loaded on the previous
// edge. There is no backpressure. An unknown in_valid is treated as low.
module decoder
  import decoder_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEC_DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] input_bits,
  input  logic                 in_valid,
  output logic [BIT_WIDTH-1:0] output_bits,
  output logic                 out_valid,
  output logic                 out_of_range
);

  logic [BIT_WIDTH-1:0] dec_onehot_w;
  logic                 dec_oor_w;

  decoder_onehot_core #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_core (
    .index_i        (input_bits),
    .onehot_o       (dec_onehot_w),
    .out_of_range_o (dec_oor_w)
  );

`ifdef DECODER_COMB_OUT_EN

  // Clock and reset have no effect in the bypass build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  // Zero-latency bypass; an unknown in_valid resolves to 0.
  always_comb begin
    output_bits  = dec_onehot_w;
    out_of_range = dec_oor_w;
    if (in_valid) begin
      out_valid = 1'b1;
    end else begin
      out_valid = 1'b0;
    end
  end

`else

  logic [BIT_WIDTH-1:0] bits_q, bits_d;
  logic                 oor_q, oor_d;
  logic                 valid_q, valid_d;

  // Next state: load a fresh decode on valid, otherwise hold; an unknown
  // in_valid falls into the hold branch.
  always_comb begin
    bits_d  = bits_q;
    oor_d   = oor_q;
    valid_d = 1'b0;
    if (in_valid) begin
      bits_d  = dec_onehot_w;
      oor_d   = dec_oor_w;
      valid_d = 1'b1;
    end
  end

  // Output register stage; reset wins over any pending decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q  <= '0;
      oor_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      bits_q  <= bits_d;
      oor_q   <= oor_d;
      valid_q <= valid_d;
    end
  end

  // Drive ports from the register stage.
  always_comb begin
    output_bits  = bits_q;
    out_of_range = oor_q;
    out_valid    = valid_q;
  end

`endif

endmodule

// File: tb/tb_decoder.sv
// tb_decoder: directed, table-driven bench for the decoder top level.
// Registered build by default; with DECODER_COMB_OUT_EN it sweeps the
// combinational bypass instead.
module tb_decoder;

  localparam int W = 20;

  logic         clk;
  logic         rst;
  logic [W-1:0] input_bits;
  logic         in_valid;
  logic [W-1:0] output_bits;
  logic         out_valid;
  logic         out_of_range;

  int checks;
  int failures;

  decoder #(
    .BIT_WIDTH (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .input_bits   (input_bits),
    .in_valid     (in_valid),
    .output_bits  (output_bits),
    .out_valid    (out_valid),
    .out_of_range (out_of_range)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures = failures + 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  typedef struct {
    string        name;
    logic         rst;
    logic         vld;
    logic [W-1:0] idx;
    logic [W-1:0] exp_bits;
    logic         exp_valid;
    logic         exp_oor;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [W-1:0] eb,
                           input logic ev, input logic eo);
    check({name, ".bits"}, 64'(output_bits), 64'(eb));
    check({name, ".valid"}, 64'(out_valid), 64'(ev));
    check({name, ".oor"}, 64'(out_of_range), 64'(eo));
    check({name, ".popcount"}, 64'($countones(output_bits) <= 1), 64'(1));
  endtask

  // Reference decode written independently of the RTL helpers.
  function automatic logic [W-1:0] ref_onehot(input int unsigned i);
    logic [W-1:0] v;
    v = '0;
    if (i < W) v[i] = 1'b1;
    return v;
  endfunction

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] idx);
    @(negedge clk);
    rst        = r;
    in_valid   = v;
    input_bits = idx;
    @(posedge clk);
    #1;
  endtask

`ifndef DECODER_COMB_OUT_EN
  vec_t vecs[$];
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    input_bits = '0;

`ifdef DECODER_COMB_OUT_EN
    // Bypass: sweep indices with no reliance on clock edges.
    for (int i = 0; i < 32; i++) begin
      input_bits = W'(i);
      in_valid   = i[0];
      #1;
      check($sformatf("comb%0d", i), 64'(output_bits), 64'(ref_onehot(i)));
      check($sformatf("comb%0d.oor", i), 64'(out_of_range), 64'(i >= W));
      check($sformatf("comb%0d.valid", i), 64'(out_valid), 64'(i[0]));
    end
`else
    //                name         rst   vld   idx       bits      vld   oor
    vecs.push_back('{"rst_a",     1'b1, 1'b1, 20'd5,    20'h0,    1'b0, 1'b0});
    vecs.push_back('{"rst_b",     1'b1, 1'b1, 20'd5,    20'h0,    1'b0, 1'b0});
    vecs.push_back('{"dec0",      1'b0, 1'b1, 20'd0,    20'h00001, 1'b1, 1'b0});
    vecs.push_back('{"dec1",      1'b0, 1'b1, 20'd1,    20'h00002, 1'b1, 1'b0});
    vecs.push_back('{"dec2",      1'b0, 1'b1, 20'd2,    20'h00004, 1'b1, 1'b0});
    vecs.push_back('{"dec19",     1'b0, 1'b1, 20'd19,   20'h80000, 1'b1, 1'b0});
    vecs.push_back('{"dec20",     1'b0, 1'b1, 20'd20,   20'h0,    1'b1, 1'b1});
    vecs.push_back('{"decmax",    1'b0, 1'b1, 20'hFFFFF, 20'h0,   1'b1, 1'b1});
    vecs.push_back('{"dec7",      1'b0, 1'b1, 20'd7,    20'h00080, 1'b1, 1'b0});
    vecs.push_back('{"hold_a",    1'b0, 1'b0, 20'd3,    20'h00080, 1'b0, 1'b0});
    vecs.push_back('{"hold_b",    1'b0, 1'b0, 20'd25,   20'h00080, 1'b0, 1'b0});
    vecs.push_back('{"mid_rst",   1'b1, 1'b1, 20'd4,    20'h0,    1'b0, 1'b0});
    vecs.push_back('{"post_rst",  1'b0, 1'b1, 20'd4,    20'h00010, 1'b1, 1'b0});
    vecs.push_back('{"dec21",     1'b0, 1'b1, 20'd21,   20'h0,    1'b1, 1'b1});
    vecs.push_back('{"hold_oor",  1'b0, 1'b0, 20'd2,    20'h0,    1'b0, 1'b1});
    vecs.push_back('{"dec10",     1'b0, 1'b1, 20'd10,   20'h00400, 1'b1, 1'b0});

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].vld, vecs[k].idx);
      check_all(vecs[k].name, vecs[k].exp_bits, vecs[k].exp_valid,
                vecs[k].exp_oor);
    end

    // Back-to-back sweep of every index 0..31, 1-cycle latency each.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, W'(i));
      check_all($sformatf("sweep%0d", i), ref_onehot(i), 1'b1, i >= W);
    end

    // Valid gap then resume: hold, then the next decode lands one cycle later.
    step(1'b0, 1'b1, 20'd12);
    check_all("gap_load", 20'h01000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 20'd0);
    check_all("gap_hold", 20'h01000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 20'd0);
    check_all("gap_resume", 20'h00001, 1'b1, 1'b0);

    // Reset held across several cycles with valid high clears and stays clear.
    step(1'b1, 1'b1, 20'd6);
    check_all("long_rst_a", 20'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 20'd30);
    check_all("long_rst_b", 20'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 20'd6);
    check_all("long_rst_idle", 20'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 20'd6);
    check_all("long_rst_first", 20'h00040, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- Binary-to-one-hot decoder for the URCPU datapath, 20 bits wide by default.
- Treats input_bits as an unsigned index and drives exactly one output bit high when the index is in range.
- Supplies select lines to downstream register-file and unit-enable logic.
- Provides valid qualification, an out-of-range flag, and an optional output register stage.

Parameters:
- BIT_WIDTH, 20, width of input_bits and output_bits; legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- input_bits  input  BIT_WIDTH  unsigned binary index to decode.
- in_valid  input  1  qualifies input_bits; when unconnected or low, the decode result is not updated.
- output_bits  output  BIT_WIDTH  one-hot decode result, or all-zero.
- out_valid  output  1  output_bits/out_of_range carry a fresh decode.
- out_of_range  output  1  high when the decoded index is >= BIT_WIDTH.

Behaviour:
- Decode function, applied to the full input width, unsigned:
  - If input_bits < BIT_WIDTH: bit [input_bits] of output_bits = 1, all other bits = 0, out_of_range = 0.
  - If input_bits >= BIT_WIDTH: output_bits = 0 and out_of_range = 1.
  - The decode never wraps or truncates; e.g. 20 and 1023 with BIT_WIDTH=20 are both out of range.
- Examples at BIT_WIDTH=20:
  - 0 -> 20'b0000_0000_0000_0000_0001
  - 1 -> 20'b0000_0000_0000_0000_0010
  - 2 -> 20'b0000_0000_0000_0000_0100
  - 19 -> bit 19 only
- The one-hot invariant holds in every state: output_bits always has popcount 0 or 1.
- Registered output (default, no latency penalty beyond 1 cycle):
  - Output registers load the decode of input_bits on the rising clk edge when in_valid=1 and rst=0.
  - Latency is exactly 1 cycle.
  - out_valid is the registered copy of in_valid.
  - When in_valid=0, output_bits and out_of_range hold their last value and out_valid drops to 0 on the next edge.
- Reset: when rst=1 at a rising edge, output_bits=0, out_of_range=0, out_valid=0.
  - Reset has priority over in_valid.
  - Reset mid-stream discards the pending decode.
  - The first valid input after reset deassertion appears one cycle later.
- X/Z on in_valid is treated as 0; the output holds.
- No internal FSM; the block is a single pipeline stage.

Optional Feature:
- Macro DECODER_COMB_OUT_EN.
- When defined:
  - output_bits and out_of_range are driven combinationally from input_bits, with zero latency, regardless of clk, rst or in_valid.
  - out_valid = in_valid, combinational.
  - No flops are instantiated.
- When undefined: the registered 1-cycle behaviour above applies.

Decomposition:
- Package decoder_pkg holds:
  - the constant DEC_DEFAULT_WIDTH = 20;
  - a function dec_onehot(index, width) returning the one-hot vector;
  - a function dec_in_range(index, width).
- One combinational sub-module, decoder_onehot_core, implements the pure decode (output_bits, out_of_range).
- The top level adds the register stage, valid tracking and the DECODER_COMB_OUT_EN bypass.

Test Plan:
- Reset scenario:
  - Stimulus: assert rst for 2 cycles with in_valid=1, input_bits=5.
  - Required response: output_bits=0, out_valid=0, out_of_range=0 throughout reset.
- Sequential decode:
  - Stimulus: in_valid=1, input_bits=0,1,2 on successive cycles.
  - Required response, one cycle later each: output_bits=...0001, ...0010, ...0100, with out_valid=1 and out_of_range=0.
- Boundary:
  - input_bits=19 -> output_bits=20'h80000 with out_of_range=0.
  - input_bits=20 -> output_bits=0 with out_of_range=1.
  - input_bits=20'hFFFFF -> output_bits=0 with out_of_range=1.
- Hold:
  - Stimulus: decode 7, then drop in_valid and change input_bits to 3.
  - Required response: output_bits stays 20'h00080 and out_valid goes to 0.
- Reset mid-stream:
  - Stimulus: in_valid=1, input_bits=4, with rst=1 on the same edge.
  - Required response: outputs are 0 after that edge; input_bits=4 with rst=0 on the following edge gives 20'h00010 one cycle later.
- DECODER_COMB_OUT_EN build:
  - Stimulus: sweep input_bits 0..31 with no clock.
  - Required response: output_bits matches the one-hot reference immediately; out_of_range=1 for 20..31.
